// File: rtl/fetch_unit_pkg.sv
// Shared constants, IF/ID bundle and branch-target helper
// for the fetch stage of the 5-stage MIPS pipeline.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] PC_RESET_VAL = 32'h0000_0000;

  typedef enum logic [1:0] {
    COND_JUMP = 2'd0,
    COND_BEZ  = 2'd1,
    COND_BNE  = 2'd2
  } br_cond_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  // Word offset scaled to bytes; low bits forced to keep alignment.
  function automatic logic [31:0] br_target(
    input logic [31:0] pc,
    input logic [31:0] off
  );
    logic [31:0] t;
    t = pc + (off << 2);
    return {t[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register with freeze hold and
// flush-to-bubble.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  if_id_t q_q;
  if_id_t q_d;

  always_comb begin
    q_d = q_q;
    unique case (1'b1)
      freeze: q_d = q_q;
      flush:  q_d = '{pc: 32'h0, instr: NOP_INSTR,
                      valid: 1'b0};
      default: q_d = '{pc: pc_in, instr: instr_in,
                       valid: 1'b1};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '{pc: 32'h0, instr: NOP_INSTR,
               valid: 1'b0};
    end else begin
      q_q <= q_d;
    end
  end

  assign pc_o    = q_q.pc;
  assign instr_o = q_q.instr;
  assign valid_o = q_q.valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, branch redirect,
// IF/ID register and fetch/flush counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] PC_RESET    = PC_RESET_VAL,
  parameter int          FLUSH_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   br_taken,
  input  logic [31:0]            br_offset,
  output logic [31:0]            imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            if_id_pc,
  output logic [31:0]            if_id_instr,
  output logic                   if_id_valid,
  output logic [31:0]            fetch_count,
  output logic [FLUSH_CNT_W-1:0] flush_count
);

  logic [31:0]            pc_q, pc_d;
  logic [31:0]            fcnt_q, fcnt_d;
  logic [FLUSH_CNT_W-1:0] xcnt_q, xcnt_d;
  logic                   redirect;
  logic [31:0]            pc_plus4;

  // A bubble in ID cannot branch, and a frozen ID
  // has stale operands.
  assign redirect = br_taken & if_id_valid & ~freeze;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d   = pc_q;
    fcnt_d = fcnt_q;
    xcnt_d = xcnt_q;
    unique case (1'b1)
      freeze: ;
      redirect: begin
        pc_d   = br_target(if_id_pc, br_offset);
        xcnt_d = xcnt_q + 1'b1;
      end
      default: begin
        pc_d   = pc_plus4;
        fcnt_d = fcnt_q + 32'd1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= PC_RESET;
      fcnt_q <= '0;
      xcnt_q <= '0;
    end else begin
      pc_q   <= pc_d;
      fcnt_q <= fcnt_d;
      xcnt_q <= xcnt_d;
    end
  end

  if_id_reg u_if_id (
    .clk      (clk),
    .rst      (rst),
    .freeze   (freeze),
    .flush    (redirect),
    .pc_in    (pc_plus4),
    .instr_in (imem_rdata),
    .pc_o     (if_id_pc),
    .instr_o  (if_id_instr),
    .valid_o  (if_id_valid)
  );

  assign imem_addr   = pc_q;
  assign fetch_count = fcnt_q;
  assign flush_count = xcnt_q;

endmodule
